// File: rtl/err_check_pkg.sv
// Shared types and helpers for the stream error checker: FSM state encoding
// and a bit-population count used to accumulate bit errors.
package err_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int POP_W = 8;

  function automatic logic [POP_W-1:0] popcount(input logic [63:0] value);
    logic [POP_W-1:0] count;
    count = '0;
    for (int i = 0; i < 64; i++) begin
      count = count + POP_W'(value[i]);
    end
    return count;
  endfunction

endpackage

// File: rtl/stream_err_checker_if.sv
// Sample streams into the checker: free-running DUT samples and the
// ready/valid golden reference stream.
interface stream_err_checker_if #(
  parameter int DATA_W = 16
);

  logic              dut_valid;
  logic [DATA_W-1:0] dut_data;
  logic              ref_valid;
  logic [DATA_W-1:0] ref_data;
  logic              ref_ready;

  modport master (
    output dut_valid,
    output dut_data,
    output ref_valid,
    output ref_data,
    input  ref_ready
  );

  modport slave (
    input  dut_valid,
    input  dut_data,
    input  ref_valid,
    input  ref_data,
    output ref_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO buffering DUT samples until their golden partner arrives.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/stream_err_checker.sv
// Compares a DUT sample stream against a golden reference stream after
// discarding the DUT pipeline latency, counting sample and bit errors.
module stream_err_checker
  import err_check_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  input  logic [7:0]           skip,
  stream_err_checker_if.slave  stream,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_err_cnt,
  output logic [CNT_W-1:0]     bit_err_cnt,
  output logic [CNT_W-1:0]     first_err_idx,
  output logic                 first_err_valid,
  output logic                 overflow
);

  localparam int SUM_W = CNT_W + POP_W;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  num_lat;
  logic [CNT_W-1:0]  pair_cnt;
  logic [7:0]        skip_lat;
  logic [7:0]        skip_cnt;
  logic              start_ok;
  logic              last_pair;
  logic              ref_ready_int;
  logic              push;
  logic              pop;
  logic              flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] diff;
  logic [SUM_W-1:0]  bit_sum;
  logic              bit_sat;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (stream.dut_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign start_ok         = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_pair        = ((pair_cnt + CNT_W'(1)) == num_lat);
  assign stream.ref_ready = ref_ready_int;

  // Bit errors are summed in a wider word so saturation can be detected
  // even when a single pair contributes more bits than CNT_W can hold.
  assign diff    = head ^ stream.ref_data;
  assign bit_sum = SUM_W'(bit_err_cnt) + SUM_W'(popcount(64'(diff)));
  assign bit_sat = |bit_sum[SUM_W-1:CNT_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    ref_ready_int = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    flush         = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (skip == 8'd0) ? ST_RUN : ST_SKIP;
        end
      end
      ST_SKIP: begin
        busy = 1'b1;
        if (stream.dut_valid && (skip_cnt == skip_lat - 8'd1)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy          = 1'b1;
        flush         = 1'b0;
        ref_ready_int = !fifo_empty;
        push          = stream.dut_valid;
        pop           = !fifo_empty && stream.ref_valid;
        if ((num_lat == '0) || (pop && last_pair)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt = (skip == 8'd0) ? ST_RUN : ST_SKIP;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Run configuration, discard counter and all result registers; a new run
  // wipes the previous results, otherwise DONE simply holds them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_lat         <= '0;
      skip_lat        <= '0;
      skip_cnt        <= '0;
      pair_cnt        <= '0;
      sample_err_cnt  <= '0;
      bit_err_cnt     <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      overflow        <= 1'b0;
    end else if (start_ok) begin
      num_lat         <= num_samples;
      skip_lat        <= skip;
      skip_cnt        <= '0;
      pair_cnt        <= '0;
      sample_err_cnt  <= '0;
      bit_err_cnt     <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      if ((state == ST_SKIP) && stream.dut_valid) begin
        skip_cnt <= skip_cnt + 8'd1;
      end
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        pair_cnt    <= pair_cnt + CNT_W'(1);
        bit_err_cnt <= bit_sat ? {CNT_W{1'b1}} : bit_sum[CNT_W-1:0];
        if (diff != '0) begin
          if (sample_err_cnt != {CNT_W{1'b1}}) begin
            sample_err_cnt <= sample_err_cnt + CNT_W'(1);
          end
          if (!first_err_valid) begin
            first_err_idx   <= pair_cnt;
            first_err_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_err_checker.sv
// Directed bench: a default-sized checker for the long runs and a small one
// (CNT_W=4, FIFO_DEPTH=4) for overflow and saturation corners.
module tb_stream_err_checker;

  logic        clk;
  logic        rst;

  logic        m_start;
  logic [31:0] m_num;
  logic [7:0]  m_skip;
  logic        m_busy, m_done, m_first_valid, m_overflow;
  logic [31:0] m_sample_err, m_bit_err, m_first_idx;

  logic        s_start;
  logic [3:0]  s_num;
  logic [7:0]  s_skip;
  logic        s_busy, s_done, s_first_valid, s_overflow;
  logic [3:0]  s_sample_err, s_bit_err, s_first_idx;

  logic [15:0] m_refs [0:127];
  logic [15:0] s_refs [0:31];
  int          m_ridx;
  int          s_ridx;
  int          tests;
  int          fails;

  stream_err_checker_if #(.DATA_W(16)) m_if ();
  stream_err_checker_if #(.DATA_W(16)) s_if ();

  stream_err_checker #(.DATA_W(16), .CNT_W(32), .FIFO_DEPTH(16)) u_main (
    .clk(clk), .rst(rst), .start(m_start), .num_samples(m_num), .skip(m_skip),
    .stream(m_if.slave), .busy(m_busy), .done(m_done),
    .sample_err_cnt(m_sample_err), .bit_err_cnt(m_bit_err),
    .first_err_idx(m_first_idx), .first_err_valid(m_first_valid), .overflow(m_overflow)
  );

  stream_err_checker #(.DATA_W(16), .CNT_W(4), .FIFO_DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .num_samples(s_num), .skip(s_skip),
    .stream(s_if.slave), .busy(s_busy), .done(s_done),
    .sample_err_cnt(s_sample_err), .bit_err_cnt(s_bit_err),
    .first_err_idx(s_first_idx), .first_err_valid(s_first_valid), .overflow(s_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 4951 + 165);
  endfunction

  // Inputs change on the falling edge; outputs read there are stable values
  // of the current cycle, so a visible ref_ready means a handshake at the next edge.
  task automatic step_m(input logic dv, input logic [15:0] dd);
    @(negedge clk);
    m_start          = 1'b0;
    m_if.dut_valid   = dv;
    m_if.dut_data    = dd;
    m_if.ref_valid   = 1'b1;
    m_if.ref_data    = m_refs[m_ridx];
    if (m_if.ref_ready && m_ridx < 127) m_ridx++;
  endtask

  task automatic start_m(input logic [7:0] skip_v, input logic [31:0] num_v);
    @(negedge clk);
    m_start        = 1'b1;
    m_skip         = skip_v;
    m_num          = num_v;
    m_if.dut_valid = 1'b0;
    m_if.ref_valid = 1'b0;
    m_ridx         = 0;
  endtask

  task automatic step_s(input logic dv, input logic [15:0] dd, input logic rv);
    @(negedge clk);
    s_start        = 1'b0;
    s_if.dut_valid = dv;
    s_if.dut_data  = dd;
    s_if.ref_valid = rv;
    s_if.ref_data  = s_refs[s_ridx];
    if (rv && s_if.ref_ready && s_ridx < 31) s_ridx++;
  endtask

  task automatic start_s(input logic [3:0] num_v);
    @(negedge clk);
    s_start        = 1'b1;
    s_skip         = 8'd0;
    s_num          = num_v;
    s_if.dut_valid = 1'b0;
    s_if.ref_valid = 1'b0;
    s_ridx         = 0;
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if ({m_busy, m_done, m_first_valid, m_overflow, m_if.ref_ready} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL reset_main_flags: got %b expected 00000",
               {m_busy, m_done, m_first_valid, m_overflow, m_if.ref_ready});
    end
    tests++;
    if ({m_sample_err, m_bit_err, m_first_idx} !== 96'd0) begin
      fails++;
      $display("[TB] FAIL reset_main_counts: got %0d/%0d/%0d expected 0/0/0",
               m_sample_err, m_bit_err, m_first_idx);
    end
    tests++;
    if ({s_busy, s_done, s_first_valid, s_overflow, s_if.ref_ready, s_sample_err} !== 9'd0) begin
      fails++;
      $display("[TB] FAIL reset_small: got %b expected all zero",
               {s_busy, s_done, s_first_valid, s_overflow, s_if.ref_ready, s_sample_err});
    end
    @(negedge clk);
    rst = 1'b1;
    step_m(1'b1, 16'h1234);
    tests++;
    if (m_busy !== 1'b0 || m_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: got busy=%b done=%b expected 0 0", m_busy, m_done);
    end
  endtask

  task automatic run_main_stream(input logic [7:0] skip_v, input int num_v, input int n_dut,
                                 input int start_glitch_at);
    start_m(skip_v, num_v);
    for (int i = 0; i < n_dut; i++) begin
      step_m(1'b1, pat(i));
      if (i == 20) begin
        tests++;
        if (m_busy !== 1'b1 || m_done !== 1'b0) begin
          fails++;
          $display("[TB] FAIL busy_mid_run: got busy=%b done=%b expected 1 0", m_busy, m_done);
        end
      end
      if (i == start_glitch_at) begin
        m_start = 1'b1;
        m_num   = 32'd3;
      end
    end
    for (int c = 0; c < 60 && !m_done; c++) step_m(1'b0, 16'h0);
  endtask

  task automatic test_clean_run;
    for (int j = 0; j < 128; j++) m_refs[j] = pat(j + 13);
    run_main_stream(8'd13, 100, 113, -1);
    tests++;
    if (m_done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL clean_done: got %b expected 1", m_done);
    end
    tests++;
    if (m_sample_err !== 32'd0 || m_bit_err !== 32'd0 || m_first_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL clean_counts: got %0d/%0d/%b expected 0/0/0",
               m_sample_err, m_bit_err, m_first_valid);
    end
  endtask

  task automatic test_error_injection;
    for (int j = 0; j < 128; j++) m_refs[j] = pat(j + 13);
    m_refs[5]  = m_refs[5] ^ 16'h0001;
    m_refs[40] = m_refs[40] ^ 16'h8181;
    run_main_stream(8'd13, 100, 113, 30);
    tests++;
    if (m_done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL err_done: got %b expected 1", m_done);
    end
    tests++;
    if (m_sample_err !== 32'd2) begin
      fails++;
      $display("[TB] FAIL err_sample_cnt: got %0d expected 2", m_sample_err);
    end
    tests++;
    if (m_bit_err !== 32'd5) begin
      fails++;
      $display("[TB] FAIL err_bit_cnt: got %0d expected 5", m_bit_err);
    end
    tests++;
    if (m_first_idx !== 32'd5 || m_first_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL err_first_idx: got %0d valid=%b expected 5 valid=1",
               m_first_idx, m_first_valid);
    end
    for (int i = 0; i < 5; i++) step_m(1'b1, 16'hFFFF);
    tests++;
    if (m_done !== 1'b1 || m_sample_err !== 32'd2 || m_bit_err !== 32'd5 || m_if.ref_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL done_hold: got done=%b %0d/%0d ready=%b expected 1 2/5 0",
               m_done, m_sample_err, m_bit_err, m_if.ref_ready);
    end
  endtask

  task automatic test_zero_samples;
    start_m(8'd0, 32'd0);
    step_m(1'b0, 16'h0);
    tests++;
    if (m_busy !== 1'b1 || m_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_first_cycle: got busy=%b done=%b expected 1 0", m_busy, m_done);
    end
    step_m(1'b0, 16'h0);
    tests++;
    if (m_done !== 1'b1 || m_busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_done: got done=%b busy=%b expected 1 0", m_done, m_busy);
    end
    tests++;
    if ({m_sample_err, m_bit_err, m_first_idx} !== 96'd0 || m_first_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_counts: got %0d/%0d/%0d expected 0/0/0",
               m_sample_err, m_bit_err, m_first_idx);
    end
  endtask

  task automatic test_mid_run_reset;
    for (int j = 0; j < 128; j++) m_refs[j] = pat(j) ^ 16'h0003;
    start_m(8'd0, 32'd50);
    for (int i = 0; i < 10; i++) step_m(1'b1, pat(i));
    tests++;
    if (m_sample_err === 32'd0) begin
      fails++;
      $display("[TB] FAIL pre_reset_errors: got %0d expected nonzero", m_sample_err);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({m_busy, m_done, m_first_valid, m_overflow, m_if.ref_ready} !== 5'b0 ||
        {m_sample_err, m_bit_err, m_first_idx} !== 96'd0) begin
      fails++;
      $display("[TB] FAIL abort_reset: got flags=%b counts=%0d/%0d/%0d expected all 0",
               {m_busy, m_done, m_first_valid, m_overflow, m_if.ref_ready},
               m_sample_err, m_bit_err, m_first_idx);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step_m(1'b1, pat(i));
    tests++;
    if (m_busy !== 1'b0 || m_done !== 1'b0 || m_sample_err !== 32'd0) begin
      fails++;
      $display("[TB] FAIL quiet_after_reset: got busy=%b done=%b err=%0d expected 0 0 0",
               m_busy, m_done, m_sample_err);
    end
    for (int j = 0; j < 128; j++) m_refs[j] = pat(j);
    run_main_stream(8'd0, 10, 10, -1);
    tests++;
    if (m_done !== 1'b1 || m_sample_err !== 32'd0 || m_bit_err !== 32'd0 ||
        m_first_valid !== 1'b0 || m_overflow !== 1'b0) begin
      fails++;
      $display("[TB] FAIL fresh_run: got done=%b %0d/%0d first=%b ovf=%b expected 1 0/0 0 0",
               m_done, m_sample_err, m_bit_err, m_first_valid, m_overflow);
    end
  endtask

  task automatic test_full_push_pop;
    for (int j = 0; j < 32; j++) s_refs[j] = pat(j);
    start_s(4'd6);
    for (int i = 0; i < 4; i++) step_s(1'b1, pat(i), 1'b0);
    step_s(1'b1, pat(4), 1'b1);
    step_s(1'b1, pat(5), 1'b1);
    for (int c = 0; c < 30 && !s_done; c++) step_s(1'b0, 16'h0, 1'b1);
    tests++;
    if (s_done !== 1'b1 || s_overflow !== 1'b0 || s_sample_err !== 4'd0) begin
      fails++;
      $display("[TB] FAIL full_push_pop: got done=%b ovf=%b err=%0d expected 1 0 0",
               s_done, s_overflow, s_sample_err);
    end
  endtask

  task automatic test_overflow;
    for (int j = 0; j < 32; j++) s_refs[j] = 16'h0;
    s_refs[0] = pat(0);
    s_refs[1] = pat(1);
    s_refs[2] = pat(2) ^ 16'h0001;
    s_refs[3] = pat(3);
    s_refs[4] = pat(6);
    start_s(4'd5);
    for (int i = 0; i < 6; i++) step_s(1'b1, pat(i), 1'b0);
    tests++;
    if (s_overflow !== 1'b1) begin
      fails++;
      $display("[TB] FAIL overflow_flag: got %b expected 1", s_overflow);
    end
    for (int i = 0; i < 4; i++) step_s(1'b0, 16'h0, 1'b1);
    step_s(1'b1, pat(6), 1'b1);
    for (int c = 0; c < 30 && !s_done; c++) step_s(1'b0, 16'h0, 1'b1);
    tests++;
    if (s_done !== 1'b1 || s_sample_err !== 4'd1 || s_bit_err !== 4'd1) begin
      fails++;
      $display("[TB] FAIL overflow_pairs: got done=%b %0d/%0d expected 1 1/1",
               s_done, s_sample_err, s_bit_err);
    end
    tests++;
    if (s_first_idx !== 4'd2 || s_overflow !== 1'b1) begin
      fails++;
      $display("[TB] FAIL overflow_first_idx: got %0d ovf=%b expected 2 ovf=1",
               s_first_idx, s_overflow);
    end
  endtask

  // num_samples is CNT_W wide, so 15 pairs is the longest run the small
  // instance can do; each pair carries 16 bit errors to push bit_err past 15.
  task automatic test_saturation;
    for (int j = 0; j < 32; j++) s_refs[j] = pat(j) ^ 16'hFFFF;
    start_s(4'd15);
    for (int i = 0; i < 15; i++) step_s(1'b1, pat(i), 1'b1);
    for (int c = 0; c < 30 && !s_done; c++) step_s(1'b0, 16'h0, 1'b1);
    tests++;
    if (s_done !== 1'b1 || s_sample_err !== 4'd15) begin
      fails++;
      $display("[TB] FAIL sat_sample_cnt: got done=%b %0d expected 1 15", s_done, s_sample_err);
    end
    tests++;
    if (s_bit_err !== 4'd15) begin
      fails++;
      $display("[TB] FAIL sat_bit_cnt: got %0d expected 15", s_bit_err);
    end
    tests++;
    if (s_first_idx !== 4'd0 || s_first_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL sat_first_idx: got %0d valid=%b expected 0 valid=1",
               s_first_idx, s_first_valid);
    end
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    m_ridx         = 0;
    s_ridx         = 0;
    rst            = 1'b0;
    m_start        = 1'b0;
    m_num          = '0;
    m_skip         = '0;
    s_start        = 1'b0;
    s_num          = '0;
    s_skip         = '0;
    m_if.dut_valid = 1'b0;
    m_if.dut_data  = '0;
    m_if.ref_valid = 1'b0;
    m_if.ref_data  = '0;
    s_if.dut_valid = 1'b0;
    s_if.dut_data  = '0;
    s_if.ref_valid = 1'b0;
    s_if.ref_data  = '0;
    for (int j = 0; j < 128; j++) m_refs[j] = '0;
    for (int j = 0; j < 32; j++) s_refs[j] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_clean_run();
    test_error_injection();
    test_zero_samples();
    test_mid_run_reset();
    test_full_push_pop();
    test_overflow();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
